// File: rtl/brg_prog.sv
// brg_prog: programmable baud-rate generator; rx_tick every D+1 enabled cycles, tx_tick every OVERSAMPLE rx ticks.
// Define BRG_FRAC_EN to add a fractional accumulator whose carry stretches the next rx period to D+2 cycles.
module brg_prog #(
    parameter int SYS_CLK      = 20000000,
    parameter int DEFAULT_BAUD = 9600,
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_in,
`ifdef BRG_FRAC_EN
    input  logic [FRAC_W-1:0] frac_in,
`endif
    output logic [DIV_W-1:0] div_q,
    output logic             rx_tick,
    output logic             tx_tick,
    output logic             rx_baud_clk,
    output logic             tx_baud_clk
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(SYS_CLK / (DEFAULT_BAUD * OVERSAMPLE) - 1);
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);

    if (OVERSAMPLE < 2) begin : g_bad_os
        $error("brg_prog: OVERSAMPLE must be at least 2");
    end
    if (FRAC_W < 1) begin : g_bad_frac
        $error("brg_prog: FRAC_W must be at least 1");
    end

    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic             rx_tick_q, rx_tick_d;
    logic             tx_tick_q, tx_tick_d;
    logic             rx_clk_q, rx_clk_d;
    logic             tx_clk_q, tx_clk_d;
    logic             at_top;
    logic             stretch;
    logic             wrap;

`ifdef BRG_FRAC_EN
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              ext_q, ext_d;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc_q} + {1'b0, frac_q};
    // A pending carry holds the counter at D for one extra cycle before wrapping.
    assign stretch = ext_q;
`else
    assign stretch = 1'b0;
`endif

    assign at_top = (rx_cnt_q == div_q);
    assign wrap   = at_top & ~stretch;

    always_comb begin
        div_d     = div_q;
        rx_cnt_d  = rx_cnt_q;
        os_cnt_d  = os_cnt_q;
        rx_tick_d = 1'b0;
        tx_tick_d = 1'b0;
        rx_clk_d  = rx_clk_q;
        tx_clk_d  = tx_clk_q;
`ifdef BRG_FRAC_EN
        frac_d    = frac_q;
        acc_d     = acc_q;
        ext_d     = ext_q;
`endif
        if (div_load) begin
            div_d    = div_in;
            rx_cnt_d = '0;
            os_cnt_d = '0;
`ifdef BRG_FRAC_EN
            frac_d   = frac_in;
            acc_d    = '0;
            ext_d    = 1'b0;
`endif
        end else if (enable) begin
            if (!at_top) begin
                rx_cnt_d = rx_cnt_q + 1'b1;
            end else if (wrap) begin
                rx_cnt_d  = '0;
                rx_tick_d = 1'b1;
                rx_clk_d  = ~rx_clk_q;
                if (os_cnt_q == OS_LAST) begin
                    os_cnt_d  = '0;
                    tx_tick_d = 1'b1;
                    tx_clk_d  = ~tx_clk_q;
                end else begin
                    os_cnt_d = os_cnt_q + 1'b1;
                end
`ifdef BRG_FRAC_EN
                acc_d = acc_sum[FRAC_W-1:0];
                ext_d = acc_sum[FRAC_W];
`endif
            end
`ifdef BRG_FRAC_EN
            else begin
                ext_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= DEF_DIV;
            rx_cnt_q  <= '0;
            os_cnt_q  <= '0;
            rx_tick_q <= 1'b0;
            tx_tick_q <= 1'b0;
            rx_clk_q  <= 1'b0;
            tx_clk_q  <= 1'b0;
`ifdef BRG_FRAC_EN
            frac_q    <= '0;
            acc_q     <= '0;
            ext_q     <= 1'b0;
`endif
        end else begin
            div_q     <= div_d;
            rx_cnt_q  <= rx_cnt_d;
            os_cnt_q  <= os_cnt_d;
            rx_tick_q <= rx_tick_d;
            tx_tick_q <= tx_tick_d;
            rx_clk_q  <= rx_clk_d;
            tx_clk_q  <= tx_clk_d;
`ifdef BRG_FRAC_EN
            frac_q    <= frac_d;
            acc_q     <= acc_d;
            ext_q     <= ext_d;
`endif
        end
    end

    assign rx_tick     = rx_tick_q;
    assign tx_tick     = tx_tick_q;
    assign rx_baud_clk = rx_clk_q;
    assign tx_baud_clk = tx_clk_q;

endmodule

// File: tb/tb_brg_prog.sv
// Self-checking bench for brg_prog: directed scenarios plus random traffic against a period-level reference model.
module tb_brg_prog;

    localparam int SYS_CLK      = 20000000;
    localparam int DEFAULT_BAUD = 9600;
    localparam int OVERSAMPLE   = 16;
    localparam int DIV_W        = 16;
    localparam int FRAC_W       = 4;
    localparam int DEF_DIV      = SYS_CLK / (DEFAULT_BAUD * OVERSAMPLE) - 1;
    localparam int ACC_MOD      = 1 << FRAC_W;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             div_load;
    logic [DIV_W-1:0] div_in;
`ifdef BRG_FRAC_EN
    logic [FRAC_W-1:0] frac_in;
`endif
    logic [DIV_W-1:0] div_q;
    logic             rx_tick;
    logic             tx_tick;
    logic             rx_baud_clk;
    logic             tx_baud_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: tracks elapsed cycles within the current rx period and the period length.
    int m_div, m_frac, m_acc, m_elapsed, m_len, m_n;
    bit m_rx, m_tx, m_rxc, m_txc;

    brg_prog #(
        .SYS_CLK(SYS_CLK), .DEFAULT_BAUD(DEFAULT_BAUD), .OVERSAMPLE(OVERSAMPLE),
        .DIV_W(DIV_W), .FRAC_W(FRAC_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .div_load(div_load), .div_in(div_in),
`ifdef BRG_FRAC_EN
        .frac_in(frac_in),
`endif
        .div_q(div_q), .rx_tick(rx_tick), .tx_tick(tx_tick),
        .rx_baud_clk(rx_baud_clk), .tx_baud_clk(tx_baud_clk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task model_edge();
        m_rx = 1'b0;
        m_tx = 1'b0;
        if (reset) begin
            m_div = DEF_DIV; m_frac = 0; m_acc = 0; m_elapsed = 0; m_n = 0;
            m_len = m_div + 1; m_rxc = 1'b0; m_txc = 1'b0;
        end else if (div_load) begin
            m_div = int'(div_in);
            m_frac = 0;
`ifdef BRG_FRAC_EN
            m_frac = int'(frac_in);
`endif
            m_acc = 0; m_elapsed = 0; m_n = 0; m_len = m_div + 1;
        end else if (enable) begin
            m_elapsed++;
            if (m_elapsed == m_len) begin
                m_elapsed = 0;
                m_rx = 1'b1;
                m_rxc = ~m_rxc;
                m_n++;
                if (m_n % OVERSAMPLE == 0) begin
                    m_tx = 1'b1;
                    m_txc = ~m_txc;
                end
                m_acc += m_frac;
                if (m_acc >= ACC_MOD) begin
                    m_acc -= ACC_MOD;
                    m_len = m_div + 2;
                end else begin
                    m_len = m_div + 1;
                end
            end
        end
    endtask

    task step();
        @(posedge clk);
        model_edge();
        #1;
        chk("div_q", 32'(div_q), 32'(m_div));
        chk("rx_tick", 32'(rx_tick), 32'(m_rx));
        chk("tx_tick", 32'(tx_tick), 32'(m_tx));
        chk("rx_baud_clk", 32'(rx_baud_clk), 32'(m_rxc));
        chk("tx_baud_clk", 32'(tx_baud_clk), 32'(m_txc));
    endtask

    task automatic wait_rx(input int maxc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (rx_tick !== 1'b1 && n < maxc);
    endtask

    task automatic wait_tx(input int maxc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (tx_tick !== 1'b1 && n < maxc);
    endtask

    initial begin
        int n, total, rx_cnt, tx_cnt;
        reset = 1'b1; enable = 1'b0; div_load = 1'b0; div_in = '0;
`ifdef BRG_FRAC_EN
        frac_in = '0;
`endif
        // Reset state
        step();
        step();
        chk("reset_div_q", 32'(div_q), 129);
        chk("reset_rx_tick", 32'(rx_tick), 0);

        // Default divisor free-running from reset release
        reset = 1'b0; enable = 1'b1;
        wait_rx(300, n);
        chk("first_rx_cycle", n, 130);
        chk("rx_baud_clk_after_first", 32'(rx_baud_clk), 1);
        wait_rx(300, n);
        chk("second_rx_gap", n, 130);
        wait_tx(2500, n);
        chk("first_tx_cycle", n + 260, 2080);

        // Reload with D=3 mid-period
        repeat (37) step();
        div_load = 1'b1; div_in = 16'd3;
        step();
        div_load = 1'b0;
        chk("load_div_q", 32'(div_q), 3);
        total = 0;
        for (int i = 0; i < 3; i++) begin
            wait_rx(20, n);
            total += n;
            chk("load_rx_offset", total, 4 * (i + 1));
        end
        wait_tx(200, n);
        chk("load_tx_offset", total + n, 64);

        // Enable held low for 50 cycles at count 60
        reset = 1'b1;
        step();
        reset = 1'b0; enable = 1'b1;
        repeat (60) step();
        enable = 1'b0;
        repeat (50) step();
        enable = 1'b1;
        wait_rx(300, n);
        chk("resume_rx_delay", 60 + 50 + n, 180);

        // D=0: rx_tick every cycle, tx_tick one cycle in 16
        div_load = 1'b1; div_in = '0;
        step();
        div_load = 1'b0;
        rx_cnt = 0; tx_cnt = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            rx_cnt += int'(rx_tick);
            tx_cnt += int'(tx_tick);
        end
        chk("d0_rx_count", rx_cnt, 48);
        chk("d0_tx_count", tx_cnt, 3);

        // Reset beats a simultaneous div_load mid-period
        reset = 1'b1;
        step();
        reset = 1'b0; enable = 1'b1;
        repeat (100) step();
        reset = 1'b1; div_load = 1'b1; div_in = 16'd7;
        step();
        chk("reset_over_load_div_q", 32'(div_q), 129);
        chk("reset_abort_rx_tick", 32'(rx_tick), 0);
        reset = 1'b0; div_load = 1'b0;
        wait_rx(300, n);
        chk("reset_release_rx", n, 130);

`ifdef BRG_FRAC_EN
        // Fractional divisor: periods 4,4,5,4,5,...
        div_load = 1'b1; div_in = 16'd3; frac_in = 4'd8;
        step();
        div_load = 1'b0;
        total = 0;
        for (int i = 0; i < 16; i++) begin
            wait_rx(20, n);
            total += n;
        end
        chk("frac_16th_rx_cycle", total, 71);
        chk("frac_first_tx", 32'(tx_tick), 1);
`endif

        // Random traffic against the model
        div_load = 1'b1; div_in = 16'd4;
        step();
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom % 600) == 0;
            div_load = ($urandom % 150) == 0;
            div_in   = 16'($urandom_range(0, 12));
`ifdef BRG_FRAC_EN
            frac_in  = 4'($urandom);
`endif
            enable   = ($urandom % 8) != 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
